// File: rtl/modexp_pkg.sv
// +----------------------------------------------------------------------+
// | modexp_pkg : widths and state encodings shared by residue/montprod   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package modexp_pkg;

  localparam int OPW = 32;
  localparam int ADW = 8;
  localparam int ITW = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SHIFT  = 3'd2,
    DECIDE = 3'd3,
    SUB    = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef enum logic {
    ALU_SHIFT = 1'b0,
    ALU_SUB   = 1'b1
  } alu_mode_e;

endpackage

`default_nettype wire

// File: rtl/residue_if.sv
// +----------------------------------------------------------------------+
// | residue_if : start/ready handshake and word-serial memory ports      |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

interface residue_if;
  import modexp_pkg::*;

  logic           calculate;
  logic           ready;
  logic [ADW-1:0] length;
  logic [ADW-1:0] opm_addr;
  logic [OPW-1:0] opm_data;
  logic [ADW-1:0] nn_rd_addr;
  logic [OPW-1:0] nn_rd_data;
  logic [ADW-1:0] nn_wr_addr;
  logic [OPW-1:0] nn_wr_data;
  logic           nn_we;

  modport master (
    input  calculate, length, opm_data, nn_rd_data,
    output ready, opm_addr, nn_rd_addr, nn_wr_addr, nn_wr_data, nn_we
  );

  modport slave (
    output calculate, length, opm_data, nn_rd_data,
    input  ready, opm_addr, nn_rd_addr, nn_wr_addr, nn_wr_data, nn_we
  );

endinterface

`default_nettype wire

// File: rtl/residue_word_alu.sv
// +----------------------------------------------------------------------+
// | residue_word_alu : per-word shift-with-compare or subtract datapath  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module residue_word_alu
  import modexp_pkg::*;
(
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  input  logic           cin_i,
  input  logic           bin_i,
  input  alu_mode_e      mode_i,
  output logic [OPW-1:0] word_o,
  output logic           cout_o,
  output logic           cmp_bout_o
);

  logic [OPW-1:0] w_shl;
  logic [OPW:0]   w_sub;
  logic [OPW:0]   w_cmp;

  always_comb begin
    w_shl = {a_i[OPW-2:0], cin_i};
    w_sub = {1'b0, a_i} - {1'b0, b_i} - {{OPW{1'b0}}, cin_i};
    // Trial subtract of the shifted word: only the borrow chain matters.
    w_cmp = {1'b0, w_shl} - {1'b0, b_i} - {{OPW{1'b0}}, bin_i};
    if (mode_i == ALU_SHIFT) begin
      word_o = w_shl;
      cout_o = a_i[OPW-1];
    end else begin
      word_o = w_sub[OPW-1:0];
      cout_o = w_sub[OPW];
    end
    cmp_bout_o = w_cmp[OPW];
  end

endmodule

`default_nettype wire

// File: rtl/residue.sv
// +----------------------------------------------------------------------+
// | residue  : computes NN = R^2 mod M by repeated modular doubling      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module residue
  import modexp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  residue_if.master  bus
);

  state_e         state_q, state_d;
  logic [ADW-1:0] len_q,   len_d;
  logic [ADW-1:0] idx_q,   idx_d;
  logic [ITW-1:0] iter_q,  iter_d;
  logic           carry_q, carry_d;
  logic           borrow_q, borrow_d;

  logic [ADW-1:0] w_last_idx;
  logic [OPW-1:0] w_word;
  logic           w_cout;
  logic           w_cmp_bout;
  alu_mode_e      w_mode;

  assign w_last_idx = len_q - ADW'(1);

  residue_word_alu u_alu (
    .a_i        (bus.nn_rd_data),
    .b_i        (bus.opm_data),
    .cin_i      (carry_q),
    .bin_i      (borrow_q),
    .mode_i     (w_mode),
    .word_o     (w_word),
    .cout_o     (w_cout),
    .cmp_bout_o (w_cmp_bout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      iter_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      iter_q   <= iter_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    idx_d          = idx_q;
    iter_d         = iter_q;
    carry_d        = carry_q;
    borrow_d       = borrow_q;
    w_mode         = ALU_SHIFT;
    bus.ready      = 1'b0;
    bus.nn_we      = 1'b0;
    bus.opm_addr   = '0;
    bus.nn_rd_addr = '0;
    bus.nn_wr_addr = '0;
    bus.nn_wr_data = '0;

    case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.calculate) begin
          len_d    = bus.length;
          idx_d    = bus.length - ADW'(1);
          carry_d  = 1'b0;
          borrow_d = 1'b0;
          state_d  = (bus.length == '0) ? DONE : INIT;
        end
      end

      INIT: begin
        bus.nn_we      = 1'b1;
        bus.nn_wr_addr = idx_q;
        bus.nn_wr_data = (idx_q == w_last_idx) ? OPW'(1) : '0;
        if (idx_q == '0) begin
          idx_d   = w_last_idx;
          iter_d  = ITW'({len_q, 6'b0});
          state_d = SHIFT;
        end else begin
          idx_d = idx_q - ADW'(1);
        end
      end

      SHIFT: begin
        bus.nn_we      = 1'b1;
        bus.opm_addr   = idx_q;
        bus.nn_rd_addr = idx_q;
        bus.nn_wr_addr = idx_q;
        bus.nn_wr_data = w_word;
        carry_d        = w_cout;
        borrow_d       = w_cmp_bout;
        if (idx_q == '0) begin
          state_d = DECIDE;
        end else begin
          idx_d = idx_q - ADW'(1);
        end
      end

      DECIDE: begin
        idx_d   = w_last_idx;
        carry_d = 1'b0;
        // 2*NN >= M when it overflowed N bits or the trial subtract did not borrow.
        if (carry_q || !borrow_q) begin
          state_d = SUB;
        end else begin
          borrow_d = 1'b0;
          iter_d   = iter_q - ITW'(1);
          state_d  = (iter_q == ITW'(1)) ? DONE : SHIFT;
        end
      end

      SUB: begin
        w_mode         = ALU_SUB;
        bus.nn_we      = 1'b1;
        bus.opm_addr   = idx_q;
        bus.nn_rd_addr = idx_q;
        bus.nn_wr_addr = idx_q;
        bus.nn_wr_data = w_word;
        carry_d        = w_cout;
        if (idx_q == '0) begin
          carry_d  = 1'b0;
          borrow_d = 1'b0;
          idx_d    = w_last_idx;
          iter_d   = iter_q - ITW'(1);
          state_d  = (iter_q == ITW'(1)) ? DONE : SHIFT;
        end else begin
          idx_d = idx_q - ADW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_residue.sv
// +----------------------------------------------------------------------+
// | tb_residue : directed vector bench for residue                       |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_residue;
  import modexp_pkg::*;

  logic clk = 1'b0;
  logic reset;

  residue_if bus ();

  residue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [OPW-1:0] opm_mem [256];
  logic [OPW-1:0] nn_mem  [256];

  assign bus.opm_data   = opm_mem[bus.opm_addr];
  assign bus.nn_rd_data = nn_mem[bus.nn_rd_addr];

  int wr_total  = 0;
  int shift_wr  = 0;
  int addr_viol = 0;
  int cur_len   = 0;
  int checks    = 0;
  int failures  = 0;

  always @(posedge clk) begin
    if (bus.nn_we) begin
      nn_mem[bus.nn_wr_addr] <= bus.nn_wr_data;
      wr_total <= wr_total + 1;
      if (dut.state_q == SHIFT) shift_wr <= shift_wr + 1;
      if (int'(bus.nn_wr_addr) >= cur_len) addr_viol <= addr_viol + 1;
    end
  end

  typedef struct {
    int          len;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] e0;
    logic [31:0] e1;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Independent reference: 2^(64L) mod M = ((2^(64L)-1) mod M + 1) mod M
  function automatic logic [63:0] ref_nn(input int len, input logic [31:0] m0, input logic [31:0] m1);
    logic [127:0] mm;
    logic [127:0] ones;
    logic [127:0] r;
    if (len == 1) begin
      mm   = {96'd0, m0};
      ones = {64'd0, {64{1'b1}}};
    end else begin
      mm   = {64'd0, m0, m1};
      ones = {128{1'b1}};
    end
    r = ((ones % mm) + 128'd1) % mm;
    return r[63:0];
  endfunction

  task automatic load_m(input int len, input logic [31:0] m0, input logic [31:0] m1);
    for (int i = 0; i < 256; i++) nn_mem[i] = 32'hDEAD_BEEF;
    opm_mem[0] = m0;
    if (len == 2) opm_mem[1] = m1;
  endtask

  task automatic run(input int len, input bit inject, output int cycles, output bit pulsed);
    cur_len = len;
    pulsed  = 1'b0;
    @(posedge clk); #1;
    bus.length    = ADW'(len);
    bus.calculate = 1'b1;
    @(posedge clk); #1;
    bus.calculate = 1'b0;
    cycles = 1;
    while (!bus.ready && cycles < 5000) begin
      if (inject && !pulsed && cycles >= 20 && dut.state_q == SHIFT) begin
        bus.calculate = 1'b1;
        pulsed = 1'b1;
      end
      @(posedge clk); #1;
      bus.calculate = 1'b0;
      cycles++;
    end
    chk("ready_at_end", 64'(bus.ready), 64'd1);
  endtask

  task automatic get_result(input int len, output logic [63:0] res);
    if (len == 1) res = {32'd0, nn_mem[0]};
    else          res = {nn_mem[0], nn_mem[1]};
  endtask

  initial begin
    int          cyc;
    bit          pulsed;
    int          w0;
    int          s0;
    int          v0;
    int          waited;
    logic [63:0] res;
    logic [63:0] expv;

    vecs[0] = '{1, 32'h0000_0013, 32'h0, 32'h0000_0011, 32'h0, 162};
    vecs[1] = '{1, 32'h0000_0011, 32'h0, 32'h0000_0001, 32'h0, 163};
    vecs[2] = '{1, 32'h0000_000b, 32'h0, 32'h0000_0005, 32'h0, -1};
    vecs[3] = '{1, 32'h0001_0001, 32'h0, 32'h0000_0001, 32'h0, -1};
    vecs[4] = '{1, 32'h7fff_ffff, 32'h0, 32'h0000_0004, 32'h0, -1};
    vecs[5] = '{1, 32'hffff_fffb, 32'h0, 32'h0000_0019, 32'h0, -1};
    vecs[6] = '{1, 32'h0000_0003, 32'h0, 32'h0000_0001, 32'h0, -1};
    vecs[7] = '{2, 32'h0000_0001, 32'h0000_0001, 32'h0, 32'h1, 516};
    vecs[8] = '{2, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 32'h1, -1};
    vecs[9] = '{2, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0, -2};

    for (int i = 0; i < 256; i++) opm_mem[i] = '0;
    bus.calculate = 1'b0;
    bus.length    = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_we", 64'(bus.nn_we), 64'd0);
    chk("rst_wr_addr", 64'(bus.nn_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.nn_wr_data), 64'd0);
    chk("rst_opm_addr", 64'(bus.opm_addr), 64'd0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      load_m(vecs[k].len, vecs[k].m0, vecs[k].m1);
      w0 = wr_total;
      s0 = shift_wr;
      v0 = addr_viol;
      run(vecs[k].len, 1'b0, cyc, pulsed);
      get_result(vecs[k].len, res);
      if (vecs[k].lat != -2) begin
        expv = (vecs[k].len == 1) ? {32'd0, vecs[k].e0} : {vecs[k].e0, vecs[k].e1};
        chk($sformatf("vec%0d_result", k), res, expv);
      end
      chk($sformatf("vec%0d_model", k), res, ref_nn(vecs[k].len, vecs[k].m0, vecs[k].m1));
      if (vecs[k].lat >= 0) chk($sformatf("vec%0d_latency", k), 64'(cyc), 64'(vecs[k].lat));
      chk($sformatf("vec%0d_shift_writes", k), 64'(shift_wr - s0), 64'(64 * vecs[k].len * vecs[k].len));
      chk($sformatf("vec%0d_addr_range", k), 64'(addr_viol - v0), 64'd0);
      chk($sformatf("vec%0d_min_writes", k), 64'(wr_total - w0 >= vecs[k].len + 64 * vecs[k].len * vecs[k].len), 64'd1);
    end

    // Zero length: straight through DONE, no memory traffic.
    w0 = wr_total;
    run(0, 1'b0, cyc, pulsed);
    chk("len0_latency_le3", 64'(cyc <= 3), 64'd1);
    chk("len0_writes", 64'(wr_total - w0), 64'd0);

    // Start pulse while busy must not disturb the run.
    load_m(1, 32'h13, 32'h0);
    run(1, 1'b1, cyc, pulsed);
    get_result(1, res);
    chk("busy_pulse_issued", 64'(pulsed), 64'd1);
    chk("busy_pulse_result", res, 64'h11);
    chk("busy_pulse_latency", 64'(cyc), 64'd162);

    // Reset in the middle of a subtract pass.
    load_m(1, 32'h13, 32'h0);
    cur_len = 1;
    @(posedge clk); #1;
    bus.length    = 8'd1;
    bus.calculate = 1'b1;
    @(posedge clk); #1;
    bus.calculate = 1'b0;
    waited = 0;
    while (dut.state_q != SUB && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("reached_sub", 64'(dut.state_q == SUB), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 64'(bus.ready), 64'd1);
    chk("midrst_we", 64'(bus.nn_we), 64'd0);
    chk("midrst_wr_addr", 64'(bus.nn_wr_addr), 64'd0);
    chk("midrst_wr_data", 64'(bus.nn_wr_data), 64'd0);
    reset = 1'b0;
    run(1, 1'b0, cyc, pulsed);
    get_result(1, res);
    chk("rerun_result", res, 64'h11);
    chk("rerun_latency", 64'(cyc), 64'd162);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
